// File: rtl/saw_voice_scheduler.sv
// ============================================================================
// Module   : saw_voice_scheduler
// Purpose  : Shares one multi-cycle divider across NUM_VOICES saw voices,
//            producing one bipolar saw sample per enabled voice per round.
// Revision : 1.0
// ============================================================================
`default_nettype none

module saw_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int FRAC_BITS  = 20,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_enable,
    input  logic                  wl_we,
    input  logic [IDX_W-1:0]      wl_addr,
    input  logic [31:0]           wl_data,
    output logic                  div_start,
    output logic [63:0]           div_dividend,
    output logic [63:0]           div_divisor,
    input  logic                  div_done,
    input  logic [31:0]           div_quotient,
    output logic                  voice_valid,
    output logic [IDX_W-1:0]      voice_idx,
    output logic [31:0]           voice_out,
    output logic                  round_done,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SCAN  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_EMIT  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic [31:0]      c_FULL_SCALE = 32'd1 << FRAC_BITS;
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_VOICES - 1);

    logic [2:0]       state_q,    state_d;
    logic [IDX_W-1:0] cur_q,      cur_d;
    logic [IDX_W-1:0] vidx_q,     vidx_d;
    logic [31:0]      vout_q,     vout_d;
    logic [63:0]      dividend_q, dividend_d;
    logic [63:0]      divisor_q,  divisor_d;
    logic             overrun_q,  overrun_d;
    logic [31:0]      cnt_q [NUM_VOICES];
    logic [31:0]      cnt_d [NUM_VOICES];
    logic [31:0]      wl_q  [NUM_VOICES];
    logic [31:0]      wl_d  [NUM_VOICES];

    logic             scan_found;
    logic [IDX_W-1:0] scan_idx;

    // Lowest enabled voice at or above the scan pointer.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_enable[i] && (i >= int'(cur_q))) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        vidx_d     = vidx_q;
        vout_d     = vout_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        overrun_d  = overrun_q | (sample_tick && (state_q != c_IDLE));
        cnt_d      = cnt_q;
        wl_d       = wl_q;

        if (wl_we && (int'(wl_addr) < NUM_VOICES)) begin
            wl_d[wl_addr] = wl_data;
        end

        case (state_q)
            c_IDLE: begin
                if (sample_tick) begin
                    state_d = c_SCAN;
                end
            end
            c_SCAN: begin
                if (!scan_found) begin
                    state_d = c_DONE;
                end else begin
                    vidx_d = scan_idx;
                    // A zero-length period has nothing to divide: phase is pinned at 0.
                    if (wl_q[scan_idx] == 32'd0) begin
                        vout_d  = 32'd0 - c_FULL_SCALE;
                        state_d = c_EMIT;
                    end else begin
                        dividend_d = {32'd0, cnt_q[scan_idx]} << FRAC_BITS;
                        divisor_d  = {32'd0, wl_q[scan_idx]} << FRAC_BITS;
                        state_d    = c_ISSUE;
                    end
                end
            end
            c_ISSUE: begin
                state_d = c_WAIT;
            end
            c_WAIT: begin
                if (div_done) begin
                    vout_d  = (div_quotient << 1) - c_FULL_SCALE;
                    state_d = c_EMIT;
                end
            end
            c_EMIT: begin
                cnt_d[vidx_q] = (cnt_q[vidx_q] >= wl_q[vidx_q]) ? 32'd0
                                                                : cnt_q[vidx_q] + 32'd1;
                if (vidx_q == c_LAST_IDX) begin
                    state_d = c_DONE;
                end else begin
                    cur_d   = vidx_q + IDX_W'(1);
                    state_d = c_SCAN;
                end
            end
            c_DONE: begin
                cur_d   = '0;
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= c_IDLE;
            cur_q      <= '0;
            vidx_q     <= '0;
            vout_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i] <= '0;
                wl_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            vidx_q     <= vidx_d;
            vout_q     <= vout_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            wl_q       <= wl_d;
        end
    end

    assign div_start    = (state_q == c_ISSUE);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign voice_valid  = (state_q == c_EMIT);
    assign voice_idx    = vidx_q;
    assign voice_out    = vout_q;
    assign round_done   = (state_q == c_DONE);
    assign busy         = (state_q != c_IDLE);
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_saw_voice_scheduler.sv
// ============================================================================
// Module   : tb_saw_voice_scheduler
// Purpose  : Randomized rounds against a per-voice counter/table model with a
//            bench-side divider that answers after a random delay.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_saw_voice_scheduler;

    localparam int NV = 4;
    localparam int FB = 20;
    localparam int IW = 2;
    localparam logic [31:0] FS = 32'd1 << FB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] voice_enable = '0;
    logic          wl_we = 1'b0;
    logic [IW-1:0] wl_addr = '0;
    logic [31:0]   wl_data = '0;
    logic          div_start;
    logic [63:0]   div_dividend;
    logic [63:0]   div_divisor;
    logic          div_done = 1'b0;
    logic [31:0]   div_quotient = '0;
    logic          voice_valid;
    logic [IW-1:0] voice_idx;
    logic [31:0]   voice_out;
    logic          round_done;
    logic          busy;
    logic          overrun;

    saw_voice_scheduler #(.NUM_VOICES(NV), .FRAC_BITS(FB), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .voice_enable(voice_enable), .wl_we(wl_we), .wl_addr(wl_addr), .wl_data(wl_data),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient),
        .voice_valid(voice_valid), .voice_idx(voice_idx), .voice_out(voice_out),
        .round_done(round_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          usediv;
        logic [63:0] dvd;
        logic [63:0] dvs;
    } ev_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    int unsigned m_cnt [NV];
    int unsigned m_wl  [NV];
    bit          m_ovr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_cnt[i] = 0;
            m_wl[i]  = 0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_div_start"},   64'(div_start),   0);
        check({pfx, "_dividend"},    div_dividend,     0);
        check({pfx, "_divisor"},     div_divisor,      0);
        check({pfx, "_voice_valid"}, 64'(voice_valid), 0);
        check({pfx, "_voice_idx"},   64'(voice_idx),   0);
        check({pfx, "_voice_out"},   64'(voice_out),   0);
        check({pfx, "_round_done"},  64'(round_done),  0);
        check({pfx, "_busy"},        64'(busy),        0);
        check({pfx, "_overrun"},     64'(overrun),     0);
    endtask

    task automatic write_wl(input int v, input int unsigned val);
        @(negedge clk);
        wl_we   = 1'b1;
        wl_addr = IW'(v);
        wl_data = val;
        @(negedge clk);
        wl_we   = 1'b0;
        m_wl[v] = val;
    endtask

    // inject: 0 none, 1 extra tick while the divider is busy, 2 extra tick on the round_done cycle
    task automatic run_round(input logic [NV-1:0] en, input int dmin, input int dmax,
                             input bit rand_q, input int inject);
        ev_t         q[$];
        ev_t         cur;
        ev_t         e;
        int          c, pend, done_c, inj;
        bit          issued, fin, first;
        logic [31:0] qv, exp_out;
        longint unsigned s;

        voice_enable = en;
        for (int i = 0; i < NV; i++) begin
            if (en[i]) begin
                e.idx    = i;
                e.usediv = (m_wl[i] != 0);
                e.dvd    = 64'(m_cnt[i]) << FB;
                e.dvs    = 64'(m_wl[i]) << FB;
                q.push_back(e);
            end
        end
        first = 1'b1; issued = 1'b0; fin = 1'b0;
        pend = 0; done_c = -10; qv = '0; inj = inject;

        @(negedge clk);
        sample_tick = 1'b1;
        c = 0;
        while (!fin && c < 300) begin
            @(negedge clk);
            c++;
            sample_tick  = 1'b0;
            div_done     = 1'b0;
            div_quotient = $urandom;
            check("busy_in_round", 64'(busy), 1);
            if (div_start) begin
                if (q.size() == 0 || !q[0].usediv || issued) begin
                    check("unexpected_div_start", 1, 0);
                end else begin
                    if (first) begin
                        check("latency_div_start", 64'(c), 2);
                        first = 1'b0;
                    end
                    check("dividend", div_dividend, q[0].dvd);
                    check("divisor",  div_divisor,  q[0].dvs);
                    issued = 1'b1;
                    pend   = $urandom_range(dmax, dmin);
                    if (inj == 1) begin
                        sample_tick = 1'b1;
                        inj = 0;
                    end
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    check("hold_dividend", div_dividend, q[0].dvd);
                    check("hold_divisor",  div_divisor,  q[0].dvs);
                    s = q[0].dvs >> FB;
                    qv = rand_q ? 32'($urandom) : ((s == 0) ? 32'd0 : 32'(q[0].dvd / s));
                    div_done     = 1'b1;
                    div_quotient = qv;
                    done_c       = c;
                end
            end
            if (voice_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_voice_valid", 1, 0);
                end else begin
                    cur = q.pop_front();
                    if (first) begin
                        check("latency_first_valid", 64'(c), 2);
                        first = 1'b0;
                    end
                    if (cur.usediv) begin
                        check("issued_before_valid", 64'(issued), 1);
                        check("valid_after_done", 64'(c), 64'(done_c + 1));
                        exp_out = (qv << 1) - FS;
                    end else begin
                        exp_out = 32'd0 - FS;
                    end
                    check("voice_idx", 64'(voice_idx), 64'(cur.idx));
                    check("voice_out", 64'(voice_out), 64'(exp_out));
                    m_cnt[cur.idx] = (m_cnt[cur.idx] >= m_wl[cur.idx]) ? 0 : m_cnt[cur.idx] + 1;
                    issued = 1'b0;
                end
            end
            if (round_done) begin
                check("events_left", 64'(q.size()), 0);
                fin = 1'b1;
                if (inj == 2) sample_tick = 1'b1;
            end
        end
        if (!fin) check("round_timeout", 0, 1);
        if (inject != 0) m_ovr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            div_done    = 1'b0;
            check("post_div_start",   64'(div_start),   0);
            check("post_voice_valid", 64'(voice_valid), 0);
            check("post_round_done",  64'(round_done),  0);
            check("post_busy",        64'(busy),        0);
        end
        check("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic reset_in_wait();
        int  c;
        bit  seen;
        voice_enable = 4'b0001;
        @(negedge clk);
        sample_tick = 1'b1;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            sample_tick = 1'b0;
            c++;
            if (div_start) seen = 1'b1;
        end
        check("rst_saw_div_start", 64'(seen), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n      = 1'b1;
        div_done     = 1'b1;
        div_quotient = $urandom;
        check_all_zero("rst_mid");
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            div_done = 1'b0;
            check("rst_late_valid", 64'(voice_valid), 0);
            check("rst_late_start", 64'(div_start),   0);
            check("rst_late_busy",  64'(busy),        0);
        end
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        write_wl(0, 4);
        for (int r = 0; r < 6; r++) run_round(4'b0001, 3, 3, 1'b0, 0);

        for (int v = 0; v < NV; v++) write_wl(v, 3);
        for (int r = 0; r < 3; r++) run_round(4'b1010, 1, 4, 1'b0, 0);
        run_round(4'b1111, 1, 4, 1'b0, 0);

        write_wl(2, 0);
        run_round(4'b0100, 1, 4, 1'b0, 0);

        run_round(4'b0001, 2, 4, 1'b0, 2);
        run_round(4'b0011, 2, 4, 1'b1, 1);

        write_wl(0, 5);
        reset_in_wait();

        for (int v = 0; v < NV; v++) write_wl(v, $urandom_range(6, 0));
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(1, 0) == 1) write_wl($urandom_range(NV - 1, 0), $urandom_range(7, 0));
            run_round(NV'($urandom), 1, 4, 1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
